// File: rtl/siphash_pkg.sv
// Shared types and constants for the SipHash message sequencer.
package siphash_pkg;

   localparam int unsigned WORD_W       = 64;
   localparam int unsigned KEY_W        = 128;
   localparam int unsigned BYTES_W      = 4;
   localparam int unsigned COUNT_W      = 8;
   localparam int unsigned ROUNDS_W     = 4;
   localparam int unsigned WORD_BYTES   = 8;
   localparam int unsigned C_ROUNDS_DEF = 2;
   localparam int unsigned D_ROUNDS_DEF = 4;
   localparam int unsigned PAD_LEN_BYTE = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_ACCEPT,
      ST_CWAIT,
      ST_PAD,
      ST_FIN,
      ST_FWAIT
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0]  data;
      logic [BYTES_W-1:0] bytes;
      logic               last;
   } msg_word_t;

endpackage

// File: rtl/siphash_pad.sv
// Builds the final SipHash block: keeps the valid message bytes and inserts the length byte.
module siphash_pad
   import siphash_pkg::*;
(
   input  logic [WORD_W-1:0]  data,
   input  logic [BYTES_W-1:0] bytes,
   input  logic [COUNT_W-1:0] count,
   output logic [WORD_W-1:0]  block
);

   always_comb begin
      block = '0;
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
         if (4'(i) < bytes) begin
            block[8*i +: 8] = data[8*i +: 8];
         end
      end
      block[8*PAD_LEN_BYTE +: 8] = count;
   end

endmodule

// File: rtl/siphash_msg_ctrl.sv
// Message-level sequencer for the SipHash core: commands, length padding, tag capture.
// Define SIPHASH_CTRL_LONG_EN to honor the 128-bit tag mode input.
module siphash_msg_ctrl
   import siphash_pkg::*;
#(
   parameter int unsigned C_ROUNDS = C_ROUNDS_DEF,
   parameter int unsigned D_ROUNDS = D_ROUNDS_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [KEY_W-1:0]    key,
   input  logic                long,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   input  logic [BYTES_W-1:0]  in_bytes,
   input  logic                in_last,
   output logic                busy,
   output logic [KEY_W-1:0]    hash,
   output logic                hash_valid,
   output logic                err,
   output logic                core_init,
   output logic                core_compress,
   output logic                core_finalize,
   output logic                core_long,
   output logic [KEY_W-1:0]    core_key,
   output logic [WORD_W-1:0]   core_mi,
   output logic [ROUNDS_W-1:0] core_crounds,
   output logic [ROUNDS_W-1:0] core_frounds,
   input  logic                core_ready,
   input  logic                core_word_valid,
   input  logic [KEY_W-1:0]    core_word
);

   state_t              state, state_d;
   logic [COUNT_W-1:0]  count_q, count_d, count_inc;
   logic                pad_pend_q, pad_pend_d;
   logic                fin_pend_q, fin_pend_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic                long_q, long_d, long_cap;
   logic                busy_d, err_d, init_d, comp_d, fin_d, hv_d;
   logic [WORD_W-1:0]   mi_d, pad_block;
   logic [KEY_W-1:0]    hash_d;
   msg_word_t           in_word;
   logic                handshake, bytes_over, short_nonlast, word_last;
   logic [BYTES_W-1:0]  eff_bytes;

`ifdef SIPHASH_CTRL_LONG_EN
   assign long_cap = long;
`else
   logic unused_long;
   assign long_cap    = 1'b0;
   assign unused_long = long;
`endif

   assign in_word       = '{data: in_data, bytes: in_bytes, last: in_last};
   assign in_ready      = (state == ST_ACCEPT) && core_ready;
   assign handshake     = in_valid && in_ready;
   assign bytes_over    = in_word.bytes > 4'(WORD_BYTES);
   assign eff_bytes     = bytes_over ? 4'(WORD_BYTES) : in_word.bytes;
   // A short word that is not flagged last is still treated as the end of the message.
   assign short_nonlast = (in_word.bytes < 4'(WORD_BYTES)) && !in_word.last;
   assign word_last     = in_word.last || short_nonlast;
   assign count_inc     = count_q + 8'(eff_bytes);

   assign core_long    = long_q;
   assign core_key     = key_q;
   assign core_crounds = 4'(C_ROUNDS);
   assign core_frounds = 4'(D_ROUNDS);

   siphash_pad u_pad (
      .data  (in_word.data),
      .bytes (eff_bytes),
      .count (count_inc),
      .block (pad_block)
   );

   // Next-state and next-output logic; waits ignore the cycle the own command is still on the wire.
   always_comb begin
      state_d    = state;
      count_d    = count_q;
      pad_pend_d = pad_pend_q;
      fin_pend_d = fin_pend_q;
      key_d      = key_q;
      long_d     = long_q;
      busy_d     = busy;
      err_d      = err;
      init_d     = 1'b0;
      comp_d     = 1'b0;
      fin_d      = 1'b0;
      hv_d       = 1'b0;
      mi_d       = core_mi;
      hash_d     = hash;
      case (state)
         ST_IDLE: begin
            if (start) begin
               key_d      = key;
               long_d     = long_cap;
               err_d      = 1'b0;
               count_d    = '0;
               pad_pend_d = 1'b0;
               fin_pend_d = 1'b0;
               busy_d     = 1'b1;
               init_d     = 1'b1;
               state_d    = ST_INIT;
            end
         end
         ST_INIT: state_d = ST_ACCEPT;
         ST_ACCEPT: begin
            if (handshake) begin
               count_d = count_inc;
               comp_d  = 1'b1;
               state_d = ST_CWAIT;
               if (bytes_over || short_nonlast) begin
                  err_d = 1'b1;
               end
               if (!word_last) begin
                  mi_d = in_word.data;
               end else if (eff_bytes == 4'(WORD_BYTES)) begin
                  mi_d       = in_word.data;
                  pad_pend_d = 1'b1;
               end else begin
                  mi_d       = pad_block;
                  fin_pend_d = 1'b1;
               end
            end
         end
         ST_CWAIT: begin
            if (core_ready && !core_compress) begin
               if (pad_pend_q)      state_d = ST_PAD;
               else if (fin_pend_q) state_d = ST_FIN;
               else                 state_d = ST_ACCEPT;
            end
         end
         ST_PAD: begin
            if (core_ready) begin
               mi_d                       = '0;
               mi_d[8*PAD_LEN_BYTE +: 8]  = count_q;
               pad_pend_d                 = 1'b0;
               fin_pend_d                 = 1'b1;
               comp_d                     = 1'b1;
               state_d                    = ST_CWAIT;
            end
         end
         ST_FIN: begin
            if (core_ready) begin
               fin_pend_d = 1'b0;
               fin_d      = 1'b1;
               state_d    = ST_FWAIT;
            end
         end
         ST_FWAIT: begin
            if (core_ready && core_word_valid && !core_finalize) begin
               hash_d  = {long_q ? core_word[127:64] : 64'h0, core_word[63:0]};
               hv_d    = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         count_q       <= '0;
         pad_pend_q    <= 1'b0;
         fin_pend_q    <= 1'b0;
         key_q         <= '0;
         long_q        <= 1'b0;
         busy          <= 1'b0;
         err           <= 1'b0;
         core_init     <= 1'b0;
         core_compress <= 1'b0;
         core_finalize <= 1'b0;
         hash_valid    <= 1'b0;
         core_mi       <= '0;
         hash          <= '0;
      end else begin
         state         <= state_d;
         count_q       <= count_d;
         pad_pend_q    <= pad_pend_d;
         fin_pend_q    <= fin_pend_d;
         key_q         <= key_d;
         long_q        <= long_d;
         busy          <= busy_d;
         err           <= err_d;
         core_init     <= init_d;
         core_compress <= comp_d;
         core_finalize <= fin_d;
         hash_valid    <= hv_d;
         core_mi       <= mi_d;
         hash          <= hash_d;
      end
   end

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// Bench for siphash_msg_ctrl: behavioural SipHash core, byte-level reference model and scoreboard.
module tb_siphash_msg_ctrl;

   logic         clk, reset_n, start, long;
   logic [127:0] key;
   logic         in_valid, in_ready, in_last;
   logic [63:0]  in_data;
   logic [3:0]   in_bytes;
   logic         busy, hash_valid, err;
   logic [127:0] hash;
   logic         core_init, core_compress, core_finalize, core_long;
   logic [127:0] core_key;
   logic [63:0]  core_mi;
   logic [3:0]   core_crounds, core_frounds;
   logic         core_ready, core_word_valid;
   logic [127:0] core_word;

   int total = 0;
   int bad   = 0;
   int n_hv  = 0;
   logic [63:0]  exp_blk[$];
   logic [127:0] exp_tag[$];
   logic [7:0]   msg[64];

   localparam logic [127:0] K = 128'h0f0e0d0c0b0a09080706050403020100;

   siphash_msg_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start), .key(key), .long(long),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_bytes(in_bytes), .in_last(in_last), .busy(busy), .hash(hash),
      .hash_valid(hash_valid), .err(err), .core_init(core_init),
      .core_compress(core_compress), .core_finalize(core_finalize),
      .core_long(core_long), .core_key(core_key), .core_mi(core_mi),
      .core_crounds(core_crounds), .core_frounds(core_frounds),
      .core_ready(core_ready), .core_word_valid(core_word_valid),
      .core_word(core_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- SipHash arithmetic ----------------
   function automatic logic [63:0] rotl(input logic [63:0] x, input int b);
      return (x << b) | (x >> (64 - b));
   endfunction

   function automatic logic [255:0] sipround(input logic [255:0] s);
      logic [63:0] v0, v1, v2, v3;
      v0 = s[63:0]; v1 = s[127:64]; v2 = s[191:128]; v3 = s[255:192];
      v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
      v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
      v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
      v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
      return {v3, v2, v1, v0};
   endfunction

   function automatic logic [255:0] sip_rounds(input logic [255:0] s, input int n);
      logic [255:0] t;
      t = s;
      for (int i = 0; i < n; i++) t = sipround(t);
      return t;
   endfunction

   function automatic logic [255:0] sip_init(input logic [127:0] k, input bit lng);
      logic [63:0] v1;
      v1 = k[127:64] ^ 64'h646f72616e646f6d;
      if (lng) v1 = v1 ^ 64'hee;
      return {k[127:64] ^ 64'h7465646279746573, k[63:0] ^ 64'h6c7967656e657261,
              v1, k[63:0] ^ 64'h736f6d6570736575};
   endfunction

   function automatic logic [255:0] sip_compress(input logic [255:0] s, input logic [63:0] m, input int c);
      logic [255:0] t;
      t = s;
      t[255:192] = t[255:192] ^ m;
      t = sip_rounds(t, c);
      t[63:0] = t[63:0] ^ m;
      return t;
   endfunction

   function automatic logic [127:0] sip_final(input logic [255:0] s, input bit lng, input int d);
      logic [255:0] t;
      logic [63:0]  w0, w1;
      t = s;
      t[191:128] = t[191:128] ^ (lng ? 64'hee : 64'hff);
      t = sip_rounds(t, d);
      w0 = t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
      w1 = 64'h0;
      if (lng) begin
         t[127:64] = t[127:64] ^ 64'hdd;
         t = sip_rounds(t, d);
         w1 = t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
      end
      return {w1, w0};
   endfunction

   // Block b of an n-byte message in msg[], little-endian, length in the top byte of the last block.
   function automatic logic [63:0] block_of(input int b, input int n);
      logic [63:0] blk;
      blk = '0;
      if (b < n / 8) begin
         for (int j = 0; j < 8; j++) blk[8*j +: 8] = msg[8*b + j];
      end else begin
         for (int j = 0; j < n % 8; j++) blk[8*j +: 8] = msg[8*b + j];
         blk[63:56] = 8'(n);
      end
      return blk;
   endfunction

   // SipHash-2-4 of msg[0..n-1]; short tags have zero upper half.
   function automatic logic [127:0] ref_tag(input logic [127:0] k, input bit lng, input int n);
      logic [255:0] s;
      s = sip_init(k, lng);
      for (int b = 0; b <= n / 8; b++) s = sip_compress(s, block_of(b, n), 2);
      return sip_final(s, lng, 4);
   endfunction

   // ---------------- core model ----------------
   logic [255:0] c_st;
   int           c_timer;
   bit           c_fin;

   always @(posedge clk) begin
      if (!reset_n) begin
         core_ready      <= 1'b1;
         core_word_valid <= 1'b0;
         core_word       <= '0;
         c_st            <= '0;
         c_timer         <= 0;
         c_fin           <= 1'b0;
      end else begin
         if (c_timer > 0) begin
            c_timer <= c_timer - 1;
            if (c_timer == 1) begin
               core_ready      <= 1'b1;
               core_word_valid <= c_fin;
            end
         end
         if (core_init) begin
            c_st            <= sip_init(core_key, core_long);
            core_word_valid <= 1'b0;
            c_fin           <= 1'b0;
         end else if (core_compress) begin
            c_st       <= sip_compress(c_st, core_mi, int'(core_crounds));
            core_ready <= 1'b0;
            c_timer    <= int'(core_crounds) + 1;
         end else if (core_finalize) begin
            core_word <= sip_final(c_st, core_long, int'(core_frounds))
                         | (core_long ? 128'h0 : {64'hdeadbeefcafef00d, 64'h0});
            core_ready      <= 1'b0;
            core_word_valid <= 1'b0;
            c_fin           <= 1'b1;
            c_timer         <= int'(core_frounds) + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (core_compress) begin
            check("compress_ready", 128'(core_ready), 128'(1));
            if (exp_blk.size() == 0) begin
               total++; bad++;
               $display("FAIL core_mi_extra: got %h want none", core_mi);
            end else begin
               check("core_mi", 128'(core_mi), 128'(exp_blk.pop_front()));
            end
         end
         if (core_finalize) begin
            check("finalize_ready", 128'(core_ready), 128'(1));
            check("blocks_left", 128'(exp_blk.size()), 128'(0));
         end
         if (hash_valid) begin
            n_hv++;
            if (exp_tag.size() == 0) begin
               total++; bad++;
               $display("FAIL hash_extra: got %h want none", hash);
            end else begin
               check("hash", hash, exp_tag.pop_front());
            end
            check("busy_at_hv", 128'(busy), 128'(0));
         end
         if (in_ready) check("ready_busy", 128'(busy), 128'(1));
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic do_start(input logic [127:0] k, input bit lng);
      @(negedge clk);
      key = k; long = lng; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("init_pulse", 128'(core_init), 128'(1));
      check("busy_set", 128'(busy), 128'(1));
      check("err_clr", 128'(err), 128'(0));
      @(negedge clk);
      check("first_ready", 128'(in_ready), 128'(1));
   endtask

   task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input bit last);
      int g;
      in_data = d; in_bytes = nb; in_last = last; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL in_ready_timeout: got 0 want 1");
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_words(input int n, input bit force_nonlast);
      int nw, nb;
      logic [63:0] d;
      nw = (n == 0) ? 1 : (n + 7) / 8;
      for (int w = 0; w < nw; w++) begin
         nb = n - 8 * w;
         if (nb > 8) nb = 8;
         d = {8{8'ha5}};
         for (int j = 0; j < nb; j++) d[8*j +: 8] = msg[8*w + j];
         send_word(d, 4'(nb), (w == nw - 1) && !force_nonlast);
      end
   endtask

   task automatic wait_hash(input int hv0);
      int g;
      g = 0;
      while (n_hv == hv0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (n_hv == hv0) begin
         total++; bad++;
         $display("FAIL hash_timeout: got no hash_valid want one");
      end
      @(negedge clk);
      check("hv_pulse", 128'(hash_valid), 128'(0));
      check("busy_clr", 128'(busy), 128'(0));
      check("hv_count", 128'(n_hv - hv0), 128'(1));
   endtask

   task automatic run_msg(input logic [127:0] k, input bit lng, input int n, input bit force_nonlast);
      int hv0;
      bit el;
`ifdef SIPHASH_CTRL_LONG_EN
      el = lng;
`else
      el = 1'b0;
`endif
      for (int b = 0; b <= n / 8; b++) exp_blk.push_back(block_of(b, n));
      exp_tag.push_back(ref_tag(k, el, n));
      hv0 = n_hv;
      do_start(k, lng);
      send_words(n, force_nonlast);
      wait_hash(hv0);
   endtask

   // ---------------- directed sequence ----------------
   logic [127:0] t;
   logic [63:0]  blk;

   initial begin
      reset_n = 1'b0; start = 1'b0; key = '0; long = 1'b0;
      in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_hash", hash, 128'(0));
      check("rst_hv", 128'(hash_valid), 128'(0));
      check("rst_err", 128'(err), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_core_mi", 128'(core_mi), 128'(0));
      check("rst_cmds", 128'({core_init, core_compress, core_finalize}), 128'(0));
      check("crounds", 128'(core_crounds), 128'(2));
      check("frounds", 128'(core_frounds), 128'(4));
      reset_n = 1'b1;
      @(negedge clk);

      // pin the reference model to published vectors
      for (int i = 0; i < 16; i++) msg[i] = 8'(i);
      t = ref_tag(K, 1'b0, 0);
      check("pin_empty", t, 128'h726fdb47dd0e0e31);
      t = ref_tag(K, 1'b0, 8);
      check("pin_8", t, 128'h93f5f5799a932462);
      t = ref_tag(K, 1'b0, 15);
      check("pin_15", t, 128'ha129ca6149be45e5);
      blk = block_of(1, 8);
      check("pin_pad8", 128'(blk), 128'h0800000000000000);
      blk = block_of(1, 15);
      check("pin_last15", 128'(blk), 128'h0f0e0d0c0b0a0908);

      // empty message
      run_msg(K, 1'b0, 0, 1'b0);
      check("empty_tag", hash, 128'h726fdb47dd0e0e31);
      repeat (5) @(negedge clk);
      check("hash_held", hash, 128'h726fdb47dd0e0e31);

      // one full word: extra length-only block
      run_msg(K, 1'b0, 8, 1'b0);
      check("w8_tag", hash, 128'h93f5f5799a932462);

      // 15 bytes, last word of 7
      run_msg(K, 1'b0, 15, 1'b0);
      check("b15_tag", hash, 128'ha129ca6149be45e5);

      // longer messages with arbitrary content
      for (int i = 0; i < 40; i++) msg[i] = 8'($urandom_range(0, 255));
      run_msg(128'h0123456789abcdeffedcba9876543210, 1'b0, 40, 1'b0);
      run_msg(128'h55aa55aa00ff00ff1122334455667788, 1'b0, 21, 1'b0);

      // short word without last: error, finalized as if last
      msg[0] = 8'haa; msg[1] = 8'hbb; msg[2] = 8'hcc;
      run_msg(K, 1'b0, 3, 1'b1);
      check("err_set", 128'(err), 128'(1));
      run_msg(K, 1'b0, 0, 1'b0);
      check("err_stays_clr", 128'(err), 128'(0));
      check("after_err_tag", hash, 128'h726fdb47dd0e0e31);

      // reset while waiting on the core
      for (int i = 0; i < 16; i++) msg[i] = 8'(i);
      for (int b = 0; b <= 2; b++) exp_blk.push_back(block_of(b, 16));
      do_start(K, 1'b0);
      send_word(64'h0706050403020100, 4'd8, 1'b0);
      @(negedge clk);
      check("cwait_busy", 128'(busy), 128'(1));
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_hash", hash, 128'(0));
      check("mid_rst_in_ready", 128'(in_ready), 128'(0));
      exp_blk.delete();
      exp_tag.delete();
      reset_n = 1'b1;
      @(negedge clk);
      run_msg(K, 1'b0, 8, 1'b0);
      check("post_rst_tag", hash, 128'h93f5f5799a932462);

      // 128-bit tag mode request
      run_msg(K, 1'b1, 0, 1'b0);
`ifdef SIPHASH_CTRL_LONG_EN
      t = ref_tag(K, 1'b1, 0);
      check("pin_long", t, 128'h930255c71472f66de6a825ba047f81a3);
      check("long_tag", hash, 128'h930255c71472f66de6a825ba047f81a3);
      check("core_long", 128'(core_long), 128'(1));
`else
      check("long_off_hi", 128'(hash[127:64]), 128'(0));
      check("long_off_lo", 128'(hash[63:0]), 128'h726fdb47dd0e0e31);
      check("core_long", 128'(core_long), 128'(0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
